// File: rtl/bcd_seg_scan_if.sv
// Bus bundle between the BCD datapath and the seven-segment scanner.
// The datapath side (master) drives the packed BCD word, its capture strobe,
// the decimal-point mask and the blanking enable. The scanner side (slave)
// drives the active-low display pins and the frame pulse.
interface bcd_seg_scan_if;
  logic [31:0] bcd;
  logic        bcd_valid;
  logic [7:0]  dp_mask;
  logic        lz_en;
  logic [7:0]  an_n;
  logic [7:0]  seg_n;
  logic        frame_done;

  modport master (
    output bcd, bcd_valid, dp_mask, lz_en,
    input  an_n, seg_n, frame_done
  );

  modport slave (
    input  bcd, bcd_valid, dp_mask, lz_en,
    output an_n, seg_n, frame_done
  );
endinterface

// File: rtl/bcd_seg_scan.sv
// Eight-digit common-anode seven-segment scanner for a packed BCD word.
// New words are captured into a pending register and only promoted to the
// displayed (shadow) register when the digit index wraps 7->0, so a frame is
// never drawn from two different words. Leading zeros can be blanked, each
// digit has its own decimal point, and nibbles 10..15 are shown as a dash.
module bcd_seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 20
) (
  input logic            clk,
  input logic            rst,
  bcd_seg_scan_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  // Active-high glyph {g,f,e,d,c,b,a}; anything above 9 renders as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h40;
    endcase
    return g;
  endfunction

  // Bit k set means digit k must stay lit under leading-zero blanking: some
  // digit at k or above is non-zero or carries a decimal point. Digit 0 is
  // always lit so a zero value still shows "0".
  function automatic logic [7:0] keep_mask(input logic [31:0] v, input logic [7:0] dp);
    logic [7:0] m;
    logic       seen;
    m    = 8'h00;
    seen = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      seen = seen | (v[4*k +: 4] != 4'd0) | dp[k];
      m[k] = seen;
    end
    m[0] = 1'b1;
    return m;
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [31:0]      pend_bcd_r;
  logic [7:0]       pend_dp_r;
  logic             pend_flag_r;
  logic [31:0]      shadow_bcd_r;
  logic [7:0]       shadow_dp_r;
  logic [7:0]       an_n_r;
  logic [7:0]       seg_n_r;
  logic             frame_done_r;

  logic             wrap_s;
  logic             boundary_s;
  logic [7:0]       keep_s;
  logic [3:0]       cur_nib_s;
  logic             cur_dp_s;
  logic             blank_s;
  logic [7:0]       an_next_s;
  logic [7:0]       seg_next_s;

  assign wrap_s     = (cnt_r == CNT_MAX);
  assign boundary_s = wrap_s & (idx_r == 3'd7);

  // Decode the digit currently selected by the index from the shadow word.
  always_comb begin
    keep_s     = keep_mask(shadow_bcd_r, shadow_dp_r);
    cur_nib_s  = shadow_bcd_r[{idx_r, 2'b00} +: 4];
    cur_dp_s   = shadow_dp_r[idx_r];
    blank_s    = bus.lz_en & ~keep_s[idx_r];
    an_next_s  = ~(8'h01 << idx_r);
    if (blank_s) begin
      seg_next_s = 8'hFF;
    end else begin
      seg_next_s = ~{cur_dp_s, seg_decode(cur_nib_s)};
    end
  end

  // Slot counter and digit index: exact wrap at SCAN_DIV-1, index mod 8.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= 3'd0;
    end else if (wrap_s) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= idx_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Capture into pending; promote pending to shadow only at the frame edge.
  // A strobe on the boundary cycle refills pending while shadow takes the
  // older pending value, so the new word waits one more frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_bcd_r   <= 32'h0000_0000;
      pend_dp_r    <= 8'h00;
      pend_flag_r  <= 1'b0;
      shadow_bcd_r <= 32'h0000_0000;
      shadow_dp_r  <= 8'h00;
    end else begin
      if (boundary_s && pend_flag_r) begin
        shadow_bcd_r <= pend_bcd_r;
        shadow_dp_r  <= pend_dp_r;
      end
      if (bus.bcd_valid) begin
        pend_bcd_r  <= bus.bcd;
        pend_dp_r   <= bus.dp_mask;
        pend_flag_r <= 1'b1;
      end else if (boundary_s) begin
        pend_flag_r <= 1'b0;
      end
    end
  end

  // Register the display pins and the frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n_r       <= 8'hFF;
      seg_n_r      <= 8'hFF;
      frame_done_r <= 1'b0;
    end else begin
      an_n_r       <= an_next_s;
      seg_n_r      <= seg_next_s;
      frame_done_r <= boundary_s;
    end
  end

  assign bus.an_n       = an_n_r;
  assign bus.seg_n      = seg_n_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Self-checking bench for bcd_seg_scan with SCAN_DIV=4. A reference model
// counts clock edges since reset release and derives the displayed digit,
// frame pulse and displayed word from that count; randomized traffic is
// checked every cycle, alongside directed display examples.
module tb_bcd_seg_scan;

  localparam int SD    = 4;
  localparam int FRAME = 8 * SD;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic clk;
  logic rst;
  bcd_seg_scan_if bus ();

  bcd_seg_scan #(.SCAN_DIV(SD), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int          n_edge;
  logic [31:0] m_pend;
  logic [7:0]  m_pend_dp;
  logic        m_pend_flag;
  logic [31:0] m_show;
  logic [7:0]  m_show_dp;
  logic [7:0]  e_an;
  logic [7:0]  e_seg;
  logic        e_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // What digit d should look like for a displayed word, from the display rules.
  function automatic logic [7:0] ref_seg(input logic [31:0] v, input logic [7:0] dp,
                                         input int d, input logic lz);
    int top;
    logic [31:0] sh;
    top = 0;
    for (int i = 0; i < 8; i++) begin
      sh = v >> (4 * i);
      if (sh[3:0] != 4'd0 || dp[i]) top = i;
    end
    if (lz && d > top) return 8'hFF;
    sh = v >> (4 * d);
    return ~{dp[d], GLYPH[sh[3:0]]};
  endfunction

  task automatic model_reset();
    n_edge      = 0;
    m_pend      = 32'h0;
    m_pend_dp   = 8'h0;
    m_pend_flag = 1'b0;
    m_show      = 32'h0;
    m_show_dp   = 8'h0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int d;
    d     = (n_edge / SD) % 8;
    e_an  = ~(8'h01 << d);
    e_seg = ref_seg(m_show, m_show_dp, d, bus.lz_en);
    e_fd  = ((n_edge % FRAME) == FRAME - 1);
    if (e_fd && m_pend_flag) begin
      m_show      = m_pend;
      m_show_dp   = m_pend_dp;
      m_pend_flag = 1'b0;
    end
    if (bus.bcd_valid) begin
      m_pend      = bus.bcd;
      m_pend_dp   = bus.dp_mask;
      m_pend_flag = 1'b1;
    end
    n_edge++;
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    logic in_rst;
    @(posedge clk);
    in_rst = rst;
    if (!in_rst) model_edge();
    @(negedge clk);
    if (in_rst) begin
      chk("rst_an", bus.an_n, 8'hFF);
      chk("rst_seg", bus.seg_n, 8'hFF);
      chk("rst_fd", bus.frame_done, 1'b0);
    end else begin
      chk("an_n", bus.an_n, e_an);
      chk("seg_n", bus.seg_n, e_seg);
      chk("frame_done", bus.frame_done, e_fd);
    end
  endtask

  task automatic strobe(input logic [31:0] v, input logic [7:0] dp);
    bus.bcd       = v;
    bus.dp_mask   = dp;
    bus.bcd_valid = 1'b1;
    tick();
    bus.bcd_valid = 1'b0;
  endtask

  task automatic wait_fd();
    int i;
    i = 0;
    tick();
    while (bus.frame_done !== 1'b1 && i < 80) begin
      tick();
      i++;
    end
    chk("seek_fd", bus.frame_done, 1'b1);
  endtask

  task automatic digit_seg(input int d, output logic [7:0] s);
    logic [7:0] want;
    int i;
    want = ~(8'h01 << d);
    i = 0;
    while (bus.an_n !== want && i < 80) begin
      tick();
      i++;
    end
    chk("seek_an", bus.an_n, want);
    s = bus.seg_n;
  endtask

  task automatic run_to_phase(input int ph);
    int i;
    i = 0;
    while ((n_edge % FRAME) != ph && i < 80) begin
      tick();
      i++;
    end
    chk("seek_phase", n_edge % FRAME, ph);
  endtask

  initial begin
    logic [7:0] s;
    rst           = 1'b1;
    bus.bcd       = 32'h0;
    bus.bcd_valid = 1'b0;
    bus.dp_mask   = 8'h0;
    bus.lz_en     = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // idle scan after reset, lz_en=0: every digit "0"
    repeat (70) tick();
    digit_seg(3, s);  chk("idle_d3", s, 8'hC0);

    // mid-frame capture is held back until the frame edge
    wait_fd();
    repeat (10) tick();
    strobe(32'h1234_5678, 8'h00);
    digit_seg(7, s);  chk("hold_d7", s, 8'hC0);
    wait_fd();
    digit_seg(0, s);  chk("new_d0", s, 8'h80);
    digit_seg(7, s);  chk("new_d7", s, 8'hF9);

    // leading-zero blanking
    bus.lz_en = 1'b1;
    strobe(32'h0000_0405, 8'h00);
    wait_fd();
    digit_seg(0, s);  chk("lz_d0", s, 8'h92);
    digit_seg(1, s);  chk("lz_d1", s, 8'hC0);
    digit_seg(2, s);  chk("lz_d2", s, 8'h99);
    digit_seg(3, s);  chk("lz_d3", s, 8'hFF);
    digit_seg(7, s);  chk("lz_d7", s, 8'hFF);
    strobe(32'h0000_0000, 8'h00);
    wait_fd();
    digit_seg(0, s);  chk("zero_d0", s, 8'hC0);
    digit_seg(5, s);  chk("zero_d5", s, 8'hFF);

    // decimal point stops blanking
    strobe(32'h0000_0012, 8'h04);
    wait_fd();
    digit_seg(0, s);  chk("dp_d0", s, 8'hA4);
    digit_seg(1, s);  chk("dp_d1", s, 8'hF9);
    digit_seg(2, s);  chk("dp_d2", s, 8'h40);
    digit_seg(3, s);  chk("dp_d3", s, 8'hFF);

    // invalid nibble shows a dash
    strobe(32'h0000_000A, 8'h00);
    wait_fd();
    digit_seg(0, s);  chk("dash_d0", s, 8'hBF);

    // last strobe within a frame wins
    bus.lz_en = 1'b0;
    wait_fd();
    strobe(32'h1111_1111, 8'h00);
    tick();
    strobe(32'h2222_2222, 8'h00);
    wait_fd();
    digit_seg(3, s);  chk("last_wins", s, 8'hA4);

    // strobe on the boundary edge: shadow takes the older pending word
    strobe(32'h4444_4444, 8'h00);
    run_to_phase(FRAME - 1);
    strobe(32'h3333_3333, 8'h00);
    chk("bnd_fd", bus.frame_done, 1'b1);
    digit_seg(0, s);  chk("bnd_old", s, 8'h99);
    wait_fd();
    digit_seg(0, s);  chk("bnd_new", s, 8'hB0);

    // strobe while frame_done is high shows one frame later
    wait_fd();
    strobe(32'h5555_5555, 8'h00);
    digit_seg(0, s);  chk("fd_cur", s, 8'hB0);
    wait_fd();
    digit_seg(0, s);  chk("fd_next", s, 8'h92);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.bcd       = $urandom;
        if ($urandom_range(0, 1) == 1) bus.bcd = bus.bcd >> (4 * $urandom_range(1, 7));
        bus.dp_mask   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        bus.bcd_valid = 1'b1;
      end else begin
        bus.bcd_valid = 1'b0;
      end
      if ($urandom_range(0, 63) == 0) bus.lz_en = ~bus.lz_en;
      tick();
    end
    bus.bcd_valid = 1'b0;
    bus.lz_en     = 1'b0;

    // asynchronous reset at digit 5, slot 2 discards pending data
    wait_fd();
    strobe(32'h9999_9999, 8'h00);
    run_to_phase(5 * SD + 2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_an", bus.an_n, 8'hFF);
    chk("arst_seg", bus.seg_n, 8'hFF);
    chk("arst_fd", bus.frame_done, 1'b0);
    model_reset();
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rel_an", bus.an_n, 8'hFE);
    repeat (2 * FRAME) tick();
    digit_seg(4, s);  chk("rel_old_gone", s, 8'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
